// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU: 8 opcodes, valid/ready on both sides, ZF/SF/OF condition codes.
// Build option: define ALU_SHIFT_EN to implement SHL/SHR/SAR; otherwise ops 101-111 retire as illegal.
module alu_pipe #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_set_cc,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_of,
  output logic             out_illegal,
  output logic [2:0]       cc
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_OR  = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_SAR = 3'd7
  } op_e;

  localparam int MSB = WIDTH - 1;

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic             r_s1_set_cc;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_s2_valid;
  logic             r_s2_set_cc;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_of;
  logic             r_s2_illegal;
  logic [2:0]       r_cc;

  logic             w_s2_adv;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_of;
  logic             w_sub_of;
  logic [WIDTH-1:0] w_result;
  logic             w_of;
  logic             w_illegal;

  // Stage 2 may load whenever its slot is empty or being drained this cycle.
  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_adv;
  assign w_out_fire = r_s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= 3'd0;
      r_s1_set_cc <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op     <= in_op;
        r_s1_set_cc <= in_set_cc;
        r_s1_a      <= in1;
        r_s1_b      <= in2;
      end
    end
  end

  assign w_sum    = r_s1_a + r_s1_b;
  assign w_diff   = r_s1_a - r_s1_b;
  assign w_add_of = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB]  != r_s1_a[MSB]);
  assign w_sub_of = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);

`ifdef ALU_SHIFT_EN
  logic [SHW-1:0] w_shamt;
  assign w_shamt = r_s1_b[SHW-1:0];
`endif

  always_comb begin
    w_result  = '0;
    w_of      = 1'b0;
    w_illegal = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_result = w_sum;
        w_of     = w_add_of;
      end
      OP_SUB: begin
        w_result = w_diff;
        w_of     = w_sub_of;
      end
      OP_AND: w_result = r_s1_a & r_s1_b;
      OP_XOR: w_result = r_s1_a ^ r_s1_b;
      OP_OR:  w_result = r_s1_a | r_s1_b;
`ifdef ALU_SHIFT_EN
      OP_SHL: w_result = r_s1_a << w_shamt;
      OP_SHR: w_result = r_s1_a >> w_shamt;
      OP_SAR: w_result = $signed(r_s1_a) >>> w_shamt;
      default: w_result = '0;
`else
      default: w_illegal = 1'b1;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_set_cc  <= 1'b0;
      r_s2_result  <= '0;
      r_s2_of      <= 1'b0;
      r_s2_illegal <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_set_cc  <= r_s1_set_cc;
        r_s2_result  <= w_result;
        r_s2_of      <= w_of;
        r_s2_illegal <= w_illegal;
      end
    end
  end

  // Condition codes commit only when the producing beat actually leaves the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= 3'b100;
    end else if (w_out_fire && r_s2_set_cc && !r_s2_illegal) begin
      r_cc <= {(r_s2_result == '0), r_s2_result[MSB], r_s2_of};
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_of      = r_s2_of;
  assign out_illegal = r_s2_illegal;
  assign cc          = r_cc;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic against a
// queue-based reference model. Follows ALU_SHIFT_EN the same way the design does.
module tb_alu_pipe;

  localparam int W = 64;

  typedef struct {
    logic [2:0]   op;
    logic         set_cc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc_edge;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic         in_set_cc;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_of;
  logic         out_illegal;
  logic [2:0]   cc;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_set_cc(in_set_cc),
    .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_of(out_of), .out_illegal(out_illegal), .cc(cc)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  beat_t        exp_q[$];
  logic [W-1:0] got_q[$];
  logic [2:0]   m_cc;
  int           cyc;
  int           n_checks;
  int           n_errors;
  logic         last_acc;
  logic         saw_in_ready_low;

  task automatic chkw(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference ALU: overflow from a sign-extended (W+1)-bit sum, shifts by the low log2(W) bits.
  function automatic void ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic of, output logic ill);
    logic [W:0] ext;
    int         amt;
    r   = '0;
    of  = 1'b0;
    ill = 1'b0;
    amt = int'(b[5:0]);
    case (op)
      3'd0: begin
        ext = {a[W-1], a} + {b[W-1], b};
        r   = ext[W-1:0];
        of  = ext[W] != ext[W-1];
      end
      3'd1: begin
        ext = {a[W-1], a} - {b[W-1], b};
        r   = ext[W-1:0];
        of  = ext[W] != ext[W-1];
      end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      default: begin
`ifdef ALU_SHIFT_EN
        if (op == 3'd5) r = a << amt;
        else if (op == 3'd6) r = a >> amt;
        else r = $signed(a) >>> amt;
`else
        ill = 1'b1;
`endif
      end
    endcase
  endfunction

  // ---------------- per-cycle compare (called at the falling edge) ----------------
  task automatic compare_cycle();
    logic [W-1:0] er;
    logic         eof;
    logic         eill;
    logic         exp_valid;
    beat_t        nb;
    last_acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_cc = 3'b100;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk3("rst_cc", cc, 3'b100);
      chkw("rst_out_result", out_result, '0);
      chk1("rst_out_illegal", out_illegal, 1'b0);
      return;
    end
    exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].acc_edge + 1);
    chk1("out_valid", out_valid, exp_valid);
    chk1("in_ready", in_ready, !(exp_q.size() >= 2 && !out_ready));
    chk3("cc", cc, m_cc);
    if (!in_ready) saw_in_ready_low = 1'b1;
    if (exp_valid) begin
      ref_alu(exp_q[0].op, exp_q[0].a, exp_q[0].b, er, eof, eill);
      chkw("out_result", out_result, er);
      chk1("out_of", out_of, eof);
      chk1("out_illegal", out_illegal, eill);
      if (out_ready) begin
        if (exp_q[0].set_cc && !eill) m_cc = {(er == '0), er[W-1], eof};
        void'(exp_q.pop_front());
        got_q.push_back(out_result);
      end
    end
    if (in_valid && in_ready) begin
      nb.op       = in_op;
      nb.set_cc   = in_set_cc;
      nb.a        = in1;
      nb.b        = in2;
      nb.acc_edge = cyc + 1;
      exp_q.push_back(nb);
      last_acc = 1'b1;
    end
  endtask

  // One clock: compare at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Single beat through an idle pipeline with out_ready held high; returns the presented fields.
  task automatic run_one(input logic [2:0] op, input logic set_cc, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] r, output logic of,
                         output logic ill);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_set_cc = set_cc;
    in1       = a;
    in2       = b;
    tick();
    chk1("one_accepted", last_acc, 1'b1);
    in_valid = 1'b0;
    tick();
    chk1("one_latency_valid", out_valid, 1'b1);
    r   = out_result;
    of  = out_of;
    ill = out_illegal;
    tick();
    chk1("one_retired", out_valid, 1'b0);
  endtask

  logic [W-1:0] r;
  logic         of;
  logic         ill;
  logic [2:0]   cc_before;
  int           bi;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    m_cc = 3'b100;
    saw_in_ready_low = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = 3'd0;
    in_set_cc = 1'b0;
    in1 = '0;
    in2 = '0;
    out_ready = 1'b1;

    // Hand-computed anchors for the reference model.
    ref_alu(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, of, ill);
    chkw("model_add_ovf", r, 64'h8000_0000_0000_0000);
    chk1("model_add_ovf_of", of, 1'b1);
    ref_alu(3'd1, 64'h8000_0000_0000_0000, 64'd1, r, of, ill);
    chkw("model_sub_ovf", r, 64'h7FFF_FFFF_FFFF_FFFF);
    chk1("model_sub_ovf_of", of, 1'b1);

    for (int i = 0; i < 3; i++) tick();
    chk1("reset_out_valid", out_valid, 1'b0);
    chk3("reset_cc", cc, 3'b100);
    rst_n = 1'b1;
    drain();

    // ADD overflow sets OF and SF.
    run_one(3'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, of, ill);
    chkw("add_ovf_result", r, 64'h8000_0000_0000_0000);
    chk1("add_ovf_of", of, 1'b1);
    chk3("add_ovf_cc", cc, 3'b011);

    // SUB to zero: cc untouched without set_cc, then ZF only.
    run_one(3'd1, 1'b0, 64'h1234, 64'h1234, r, of, ill);
    chkw("sub_zero_result", r, 64'd0);
    chk3("sub_zero_nocc", cc, 3'b011);
    run_one(3'd1, 1'b1, 64'h1234, 64'h1234, r, of, ill);
    chk1("sub_zero_of", of, 1'b0);
    chk3("sub_zero_cc", cc, 3'b100);

    run_one(3'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, of, ill);
    chk3("add_ovf_cc2", cc, 3'b011);

    // Shift cases, expectation depends on the build.
    cc_before = cc;
    run_one(3'd7, 1'b1, 64'h8000_0000_0000_0000, 64'h43, r, of, ill);
`ifdef ALU_SHIFT_EN
    chkw("sar_result", r, 64'hF000_0000_0000_0000);
    chk1("sar_illegal", ill, 1'b0);
    chk3("sar_cc", cc, 3'b010);
    run_one(3'd5, 1'b0, 64'd1, 64'd63, r, of, ill);
    chkw("shl_result", r, 64'h8000_0000_0000_0000);
    run_one(3'd6, 1'b0, 64'hDEAD_BEEF, 64'd0, r, of, ill);
    chkw("shr_zero_amt", r, 64'hDEAD_BEEF);
`else
    chkw("sar_illegal_result", r, 64'd0);
    chk1("sar_illegal_flag", ill, 1'b1);
    chk1("sar_illegal_of", of, 1'b0);
    chk3("sar_illegal_cc", cc, cc_before);
`endif

    // Backpressure: out_ready cycles 1,0,0,1 while five ADD beats stream in.
    drain();
    got_q.delete();
    saw_in_ready_low = 1'b0;
    bi = 0;
    for (int k = 0; k < 80; k++) begin
      if (bi == 5 && got_q.size() >= 5) break;
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      in_valid  = (bi < 5);
      in_op     = 3'd0;
      in_set_cc = 1'b0;
      in1       = W'(bi);
      in2       = 64'd10;
      tick();
      if (last_acc) bi++;
    end
    in_valid = 1'b0;
    chk1("bp_all_accepted", bi == 5, 1'b1);
    chk1("bp_count", got_q.size() == 5, 1'b1);
    for (int j = 0; j < 5; j++) begin
      if (j < got_q.size()) chkw("bp_order", got_q[j], W'(10 + j));
    end
    chk1("bp_in_ready_fell", saw_in_ready_low, 1'b1);
    drain();

    // Reset with two beats in flight: nothing stale may surface afterwards.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_set_cc = 1'b1;
    in1       = 64'd5;
    in2       = 64'd6;
    tick();
    in1 = 64'd7;
    tick();
    in_valid = 1'b0;
    chk1("pre_rst_two_in_flight", exp_q.size() == 2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk3("mid_rst_cc", cc, 3'b100);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk1("post_rst_no_stale", out_valid, 1'b0);

    // Randomized traffic against the model, with one reset pulse in the middle.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_set_cc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: in1 = 64'h7FFF_FFFF_FFFF_FFFF;
        1: in1 = 64'h8000_0000_0000_0000;
        2: in1 = '0;
        default: in1 = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0: in2 = in1;
        1: in2 = 64'd1;
        2: in2 = '1;
        default: in2 = {$urandom, $urandom};
      endcase
      rst_n = !(k >= 1500 && k < 1502);
      tick();
    end
    rst_n = 1'b1;
    drain();
    chk1("final_empty", exp_q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
